ds1302_byte_io: RTL and testbench
=================================

// Module: ds1302_byte_io
// PURPOSE
//  Bit-level serial engine for the DS1302 RTC 3-wire bus. Takes one single-byte
//  read or write command per handshake from the time-register sequencer upstream.
//  Drives CE, SCLK and the bidirectional IO pin. Returns the read byte.
//  It is the only block that touches the DS1302 pins.
// PARAMETERS
//  SCLK_HALF  25   clk cycles per SCLK half-period (50 MHz -> 1 MHz SCLK)
//  CE_SU      200  clk cycles CE high before first SCLK rise (tCC >= 4 us)
//  CE_HD      50   clk cycles SCLK low before CE falls (tCCH)
//  CE_RC      200  clk cycles CE low after transfer, before ack (tCWH >= 4 us)
// PORTS
//  clk            in     1  system clock
//  rst_n          in     1  synchronous active-low reset
//  cmd_write      in     1  write request level, held until cmd_write_ack
//  cmd_read       in     1  read request level, held until cmd_read_ack
//  write_addr     in     8  command byte for writes (bit0=0), e.g. 8'h80
//  write_data     in     8  data byte for writes
//  read_addr      in     8  command byte for reads (bit0=1), e.g. 8'h81
//  cmd_write_ack  out    1  1-cycle pulse: write transfer complete
//  cmd_read_ack   out    1  1-cycle pulse: read complete; read_data valid
//  read_data      out    8  last byte read, held until next read ack
//  ds1302_ce      out    1  chip enable
//  ds1302_sclk    out    1  serial clock
//  ds1302_io      inout  1  serial data; driven only while io_oe=1, else 1'bz
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE.
//   Outputs: ce=0, sclk=0, io released (z), both acks=0, read_data=8'h00.
//   Reset mid-transfer aborts at that edge: CE drops, no ack is issued.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> RECOVER -> ACK -> IDLE.
//  IDLE: samples cmd_write/cmd_read.
//   Both high: write wins.
//   Latches op, addr and data into shadow registers; inputs are ignored afterwards.
//  SETUP: ce=1, sclk=0, io driven with addr[0]. Lasts CE_SU cycles.
//  SHIFT: 16 SCLK periods, bit counter 0..15, LSB first.
//   Each period is SCLK_HALF cycles low, then SCLK_HALF cycles high.
//   Bits 0-7 (command) are driven during the low phase; DS1302 latches on the rise.
//   Write: bits 8-15 drive data[0..7] the same way.
//   Read: io released on the falling edge after bit 7 (shift_reg, not the pin).
//   Read: io sampled on the last clk of each low phase of bits 8..15, into rd[bit-8].
//  HOLD: sclk=0, ce=1 for CE_HD cycles.
//  RECOVER: ce=0, io released, for CE_RC cycles.
//  ACK: exactly one cycle. Write op: cmd_write_ack=1.
//   Read op: cmd_read_ack=1, and read_data=rd during that same cycle (registered on entry).
//   Upstream drops cmd on this edge; IDLE re-samples next cycle, so no double trigger.
//  Latency: ack in cycle t0+1+CE_SU+32*SCLK_HALF+CE_HD+CE_RC, where t0 is the IDLE
//   sample cycle. With defaults: 1251 cycles for both ops.
//  A cmd deasserted mid-transfer does not abort; the transfer completes and acks.
//  Half-period counter 0..SCLK_HALF-1, wraps. Bit counter stops at 15, no wrap.
//  sclk is always low when ce changes. io is never driven while ce=0.
// TESTING
//  1 Reset held with cmd_read=1 -> ce/sclk=0, io=z, no ack. Release -> read starts
//    the next cycle.
//  2 cmd_write, addr 8'h80, data 8'h59 -> IO at 16 SCLK rises =
//    0000_0001,1001_1010 (LSB first); one cmd_write_ack at cycle 1251.
//  3 cmd_read, addr 8'h81, bus model returns 8'h45 -> io z after rise 8;
//    read_data=8'h45 in cmd_read_ack cycle.
//  4 cmd_read and cmd_write asserted together -> write performed, only
//    cmd_write_ack pulses.
//  5 Back-to-back 7 reads from the sequencer -> CE low >= CE_RC cycles between
//    frames; each ack exactly 1 cycle.
//  6 rst_n pulsed low during SHIFT bit 10 -> ce=0 next edge, no ack, read_data
//    unchanged; next cmd runs cleanly.

Source files
------------

// File: rtl/ds1302_byte_io.sv
// DS1302 3-wire serial engine: one command byte plus one data byte per transfer,
// LSB first, framed by CE setup, hold and recovery intervals.
module ds1302_byte_io #(
    parameter int SCLK_HALF = 25,
    parameter int CE_SU     = 200,
    parameter int CE_HD     = 50,
    parameter int CE_RC     = 200
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_write_i,
    input  logic       cmd_read_i,
    input  logic [7:0] write_addr_i,
    input  logic [7:0] write_data_i,
    input  logic [7:0] read_addr_i,
    output logic       cmd_write_ack_o,
    output logic       cmd_read_ack_o,
    output logic [7:0] read_data_o,
    output logic       ds1302_ce_o,
    output logic       ds1302_sclk_o,
    inout  wire        ds1302_io_io
);

    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RECOVER, ACK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic [3:0]    bitCnt_q;
    logic          isRead_q;
    logic [15:0]   shift_q;
    logic [7:0]    rd_q;
    logic [7:0]    readData_q;
    logic          halfDone;
    logic          accept;
    logic          ioOe;

    assign halfDone = (cnt_q == CW'(SCLK_HALF - 1));
    assign accept   = (state_q == IDLE) && (cmd_write_i || cmd_read_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_write_i || cmd_read_i) state_d = SETUP;
            SETUP:   if (cnt_q == CW'(CE_SU - 1)) state_d = SHIFT;
            SHIFT:   if (halfDone && phase_q && bitCnt_q == 4'd15) state_d = HOLD;
            HOLD:    if (cnt_q == CW'(CE_HD - 1)) state_d = RECOVER;
            RECOVER: if (cnt_q == CW'(CE_RC - 1)) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One counter times every interval; in SHIFT it is the half-period counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            bitCnt_q   <= '0;
            isRead_q   <= 1'b0;
            shift_q    <= '0;
            rd_q       <= '0;
            readData_q <= '0;
        end else begin
            if (state_d != state_q || (state_q == SHIFT && halfDone)) begin
                cnt_q <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (accept) begin
                isRead_q <= !cmd_write_i;
                shift_q  <= cmd_write_i ? {write_data_i, write_addr_i} : {8'h00, read_addr_i};
                bitCnt_q <= '0;
                phase_q  <= 1'b0;
            end

            // The bit advances as SCLK falls; read bits are sampled just before the rise.
            if (state_q == SHIFT && halfDone) begin
                phase_q <= !phase_q;
                if (phase_q) begin
                    shift_q <= {1'b0, shift_q[15:1]};
                    if (bitCnt_q != 4'd15) begin
                        bitCnt_q <= bitCnt_q + 4'd1;
                    end
                end else if (isRead_q && bitCnt_q[3]) begin
                    rd_q[bitCnt_q[2:0]] <= ds1302_io_io;
                end
            end

            if (state_q == RECOVER && state_d == ACK && isRead_q) begin
                readData_q <= rd_q;
            end
        end
    end

    always_comb begin
        ds1302_ce_o     = 1'b0;
        ds1302_sclk_o   = 1'b0;
        ioOe            = 1'b0;
        cmd_write_ack_o = 1'b0;
        cmd_read_ack_o  = 1'b0;
        case (state_q)
            SETUP: begin
                ds1302_ce_o = 1'b1;
                ioOe        = 1'b1;
            end
            SHIFT: begin
                ds1302_ce_o   = 1'b1;
                ds1302_sclk_o = phase_q;
                ioOe          = !isRead_q || !bitCnt_q[3];
            end
            HOLD: begin
                ds1302_ce_o = 1'b1;
            end
            ACK: begin
                cmd_write_ack_o = !isRead_q;
                cmd_read_ack_o  = isRead_q;
            end
            default: begin
            end
        endcase
    end

    assign ds1302_io_io = ioOe ? shift_q[0] : 1'bz;
    assign read_data_o  = readData_q;

endmodule

// File: tb/tb_ds1302_byte_io.sv
// Bench for ds1302_byte_io: a transfer-timeline model plus a small DS1302 bus
// model on a pulled-up IO line, checked every cycle and against literal values.
module tb_ds1302_byte_io;

    localparam int CLK_HALF  = 5;
    localparam int SCLK_HALF = 25;
    localparam int CE_SU     = 200;
    localparam int CE_HD     = 50;
    localparam int CE_RC     = 200;
    localparam int SHIFT_END = CE_SU + 32 * SCLK_HALF;
    localparam int CE_END    = SHIFT_END + CE_HD;
    localparam int ACK_REL   = CE_END + CE_RC;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       cmdWrite = 1'b0;
    logic       cmdRead = 1'b0;
    logic [7:0] writeAddr = 8'h00;
    logic [7:0] writeData = 8'h00;
    logic [7:0] readAddr = 8'h00;
    logic       writeAck;
    logic       readAck;
    logic [7:0] readData;
    logic       ce;
    logic       sclk;
    wire        ioBus;

    int compared = 0;
    int mismatched = 0;

    always #CLK_HALF clk = ~clk;

    pullup (ioBus);

    ds1302_byte_io #(
        .SCLK_HALF(SCLK_HALF),
        .CE_SU(CE_SU),
        .CE_HD(CE_HD),
        .CE_RC(CE_RC)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rstN),
        .cmd_write_i(cmdWrite),
        .cmd_read_i(cmdRead),
        .write_addr_i(writeAddr),
        .write_data_i(writeData),
        .read_addr_i(readAddr),
        .cmd_write_ack_o(writeAck),
        .cmd_read_ack_o(readAck),
        .read_data_o(readData),
        .ds1302_ce_o(ce),
        .ds1302_sclk_o(sclk),
        .ds1302_io_io(ioBus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // DS1302 side: capture the pin on every SCLK rise, answer reads after a short output delay.
    logic [15:0] cap = 16'h0000;
    int          riseCnt = 0;
    logic [7:0]  busByte = 8'h00;
    logic        mDrv = 1'b0;
    logic        mBit = 1'b0;
    int          pend = 0;
    logic        gapFlag = 1'b0;

    assign ioBus = mDrv ? mBit : 1'bz;

    always @(posedge ce) begin
        riseCnt = 0;
        cap = 16'h0000;
    end

    always @(negedge ce) begin
        mDrv = 1'b0;
        pend = 0;
    end

    always @(posedge sclk) begin
        if (riseCnt < 16) cap[4'(riseCnt)] = ioBus;
        riseCnt++;
    end

    always @(negedge sclk) begin
        mDrv = 1'b0;
        if (ce && cap[0] && riseCnt >= 8 && riseCnt < 16) begin
            mBit = busByte[3'(riseCnt - 8)];
            pend = 3;
            if (riseCnt == 8) gapFlag = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!ce) begin
            mDrv = 1'b0;
            pend = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) mDrv = 1'b1;
        end
    end

    // Transfer model: cycles elapsed since the accepting edge determine every output.
    logic        mBusy = 1'b0;
    logic        mIsRead = 1'b0;
    int          mRel = 0;
    logic [15:0] mWord = 16'h0000;
    logic [7:0]  expReadData = 8'h00;

    always @(posedge clk) begin
        if (!rstN) begin
            mBusy = 1'b0;
            expReadData = 8'h00;
        end else if (mBusy) begin
            if (mRel == ACK_REL) begin
                mBusy = 1'b0;
            end else begin
                mRel++;
                if (mRel == ACK_REL && mIsRead) expReadData = busByte;
            end
        end else if (cmdWrite || cmdRead) begin
            mBusy = 1'b1;
            mRel = 0;
            mIsRead = !cmdWrite;
            mWord = cmdWrite ? {writeData, writeAddr} : {8'h00, readAddr};
        end
    end

    function automatic logic [11:0] expCtl();
        logic eCe, eSclk, eW, eR;
        eCe   = mBusy && (mRel < CE_END);
        eSclk = mBusy && (mRel >= CE_SU) && (mRel < SHIFT_END) && (((mRel - CE_SU) / SCLK_HALF) % 2 == 1);
        eW    = mBusy && (mRel == ACK_REL) && !mIsRead;
        eR    = mBusy && (mRel == ACK_REL) && mIsRead;
        return {eCe, eSclk, eW, eR, expReadData};
    endfunction

    logic cmpEn = 1'b0;
    logic gapEn = 1'b0;
    int   ceLow = 0;
    logic ioKnown;
    logic ioExp;
    int   halfIdx;
    int   bitIdx;

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("ctl", 32'({ce, sclk, writeAck, readAck, readData}), 32'(expCtl()));
            ioKnown = 1'b0;
            ioExp = 1'b1;
            if (!mBusy || mRel >= CE_END) begin
                ioKnown = 1'b1;
            end else if (mRel < CE_SU) begin
                ioKnown = 1'b1;
                ioExp = mWord[0];
            end else if (mRel < SHIFT_END) begin
                halfIdx = (mRel - CE_SU) / SCLK_HALF;
                bitIdx = halfIdx / 2;
                if (halfIdx % 2 == 0 && (!mIsRead || bitIdx < 8)) begin
                    ioKnown = 1'b1;
                    ioExp = mWord[4'(bitIdx)];
                end
            end
            if (ioKnown) checkOutput("io", 32'(ioBus), 32'(ioExp));
            if (gapFlag) begin
                gapFlag = 1'b0;
                checkOutput("ioReleasedAfterCmd", 32'(ioBus), 32'd1);
            end
            if (!ce) begin
                ceLow++;
            end else begin
                if (gapEn && ceLow > 0) begin
                    compared++;
                    if (ceLow < CE_RC) begin
                        mismatched++;
                        $display("[TB] FAIL ceRecovery: CE low for %0d cycles, required at least %0d", ceLow, CE_RC);
                    end
                end
                ceLow = 0;
            end
        end
    end

    task automatic applyStimulus(input logic doWrite, input logic doRead, input logic [7:0] wAddr,
                                 input logic [7:0] wData, input logic [7:0] rAddr, input logic [7:0] rByte,
                                 output int cycles, output logic sawW, output logic sawR, output logic [7:0] ackData);
        writeAddr = wAddr;
        writeData = wData;
        readAddr = rAddr;
        busByte = rByte;
        cmdWrite = doWrite;
        cmdRead = doRead;
        cycles = 0;
        sawW = 1'b0;
        sawR = 1'b0;
        ackData = 8'h00;
        while (!(sawW || sawR) && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            sawW = writeAck;
            sawR = readAck;
            ackData = readData;
        end
        cmdWrite = 1'b0;
        cmdRead = 1'b0;
        if (!(sawW || sawR)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ackTimeout: no ack after %0d cycles, required one at cycle %0d", cycles, ACK_REL + 1);
        end else begin
            @(posedge clk);
            #1;
            checkOutput("ackWidth", 32'({writeAck, readAck}), 32'd0);
        end
    endtask

    int         cyc;
    logic       sw;
    logic       sr;
    logic [7:0] ad;
    logic       anyAck;
    logic [7:0] seqBytes [7] = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h15, 8'h06, 8'h24};

    initial begin
        // Reset held while a read is requested: pins idle, no ack.
        rstN = 1'b0;
        cmdRead = 1'b1;
        readAddr = 8'h81;
        @(posedge clk);
        #1;
        cmpEn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("resetPins", 32'({ce, sclk, writeAck, readAck, ioBus}), 32'h01);
        end
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h81, 8'h00, cyc, sw, sr, ad);
        checkOutput("resetReleaseLatency", 32'(cyc), 32'd1251);
        checkOutput("resetReleaseAck", 32'({sw, sr}), 32'b01);

        // Reset pulsed during bit 10 of a read aborts it without an ack.
        readAddr = 8'h81;
        busByte = 8'hA5;
        cmdRead = 1'b1;
        repeat (711) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abortPoint", 32'({ce, sclk}), 32'b10);
        rstN = 1'b0;
        cmdRead = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortPins", 32'({ce, sclk, writeAck, readAck}), 32'd0);
        rstN = 1'b1;
        anyAck = 1'b0;
        repeat (1300) begin
            @(posedge clk);
            #1;
            anyAck = anyAck | writeAck | readAck;
        end
        checkOutput("abortNoAck", 32'(anyAck), 32'd0);
        checkOutput("abortReadData", 32'(readData), 32'h00);

        // Write 0x59 to 0x80.
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h59, 8'h00, 8'h00, cyc, sw, sr, ad);
        checkOutput("writeLatency", 32'(cyc), 32'd1251);
        checkOutput("writeAck", 32'({sw, sr}), 32'b10);
        checkOutput("writeFrame", 32'(cap), 32'h5980);

        // Read 0x81 with the chip returning 0x45.
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h81, 8'h45, cyc, sw, sr, ad);
        checkOutput("readLatency", 32'(cyc), 32'd1251);
        checkOutput("readAck", 32'({sw, sr}), 32'b01);
        checkOutput("readData", 32'(ad), 32'h45);
        checkOutput("readCmd", 32'(cap[7:0]), 32'h81);

        // Simultaneous requests: the write wins.
        applyStimulus(1'b1, 1'b1, 8'h80, 8'h12, 8'h81, 8'h77, cyc, sw, sr, ad);
        checkOutput("bothAck", 32'({sw, sr}), 32'b10);
        checkOutput("bothFrame", 32'(cap), 32'h1280);
        checkOutput("bothReadDataKept", 32'(ad), 32'h45);

        // Seven back-to-back reads as a time-register sweep.
        gapEn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'(8'h81 + 2 * i), seqBytes[i], cyc, sw, sr, ad);
            checkOutput("seqLatency", 32'(cyc), 32'd1251);
            checkOutput("seqData", 32'(ad), 32'(seqBytes[i]));
            checkOutput("seqCmd", 32'(cap[7:0]), 32'(8'h81 + 2 * i));
        end
        gapEn = 1'b0;

        repeat (5) @(posedge clk);
        cmpEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
